// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Optional ARB_ROUND_ROBIN_EN alternates grants on ties; otherwise data wins every tie.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_be,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  generate
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       killed;
  logic       pick_dm, pick_if;
  logic       grant_dm, grant_if;
  logic       done;

`ifdef ARB_ROUND_ROBIN_EN
  // last_dm = 1 means the previous grant went to data, so fetch wins the next tie.
  logic last_dm;

  always_comb begin
    pick_dm = dm_req & (~if_req | ~last_dm);
    pick_if = if_req & ~pick_dm;
  end

  always_ff @(posedge clk) begin
    if (reset)         last_dm <= 1'b1;
    else if (grant_dm) last_dm <= 1'b1;
    else if (grant_if) last_dm <= 1'b0;
  end
`else
  assign pick_dm = dm_req;
  assign pick_if = if_req & ~dm_req;
`endif

  assign grant_dm = (state == IDLE) & pick_dm;
  assign grant_if = (state == IDLE) & pick_if;
  assign done     = (state != IDLE) & (cnt == 4'd0);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    if_ack     = 1'b0;
    dm_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_dm)      state_next = BUSY_DM;
        else if (grant_if) state_next = BUSY_IF;
      end
      BUSY_IF: begin
        if (done) begin
          state_next = IDLE;
          if_ack     = ~killed & ~reset;
        end
      end
      BUSY_DM: begin
        if (done) begin
          state_next = IDLE;
          dm_ack     = ~reset;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign if_rdata = if_ack ? mem_rdata : 32'd0;
  assign dm_rdata = (dm_ack & ~mem_we) ? mem_rdata : 32'd0;
  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the captured request fields are reset too, because they drive module outputs that must read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      killed    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
    end else begin
      mem_req <= 1'b0;
      if (grant_dm) begin
        cnt       <= LAT;
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (grant_if) begin
        cnt       <= LAT;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= 32'd0;
        mem_be    <= 4'hF;
        killed    <= if_flush;
      end else if (done) begin
        killed <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= cnt - 4'd1;
        // A flushed fetch still occupies the memory but is never acknowledged.
        if (state == BUSY_IF && if_flush) killed <= 1'b1;
      end
    end
  end

endmodule
